// File: rtl/clock_pkg.sv
// Shared definitions for the wall-clock seconds stage.
// Rollover value and button debounce state encoding.
package clock_pkg;

  localparam int SEC_ROLL = 60;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/secmod_btn_cond.sv
// Button conditioner: 2-FF sync, debounce FSM, auto-repeat.
// Emits a registered one-cycle pulse on press and on each repeat.
module btn_cond
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 200_000,
  parameter int unsigned REPEAT_DELAY  = 5_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic pressed
);

  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RD_LOAD =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LOAD =
    RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  logic [1:0]    sync_q;
  logic          lvl;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          fire;
  logic          pulse_q;

  assign lvl     = sync_q[1];
  assign pulse   = pulse_q;
  assign pressed = (state_q == PRESSED);

  // State, counters, synchronizer and pulse register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= fire;
    end
  end

  // Next state: debounce counting and repeat timer
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      RELEASED: begin
        if (lvl) begin
          state_d = (DB_LAST == '0) ?
                    PRESSED : PRESS_WAIT;
          dcnt_d  = DB_ONE;
          rcnt_d  = RD_LOAD;
        end
      end
      PRESS_WAIT: begin
        if (!lvl) begin
          state_d = RELEASED;
        end else if (dcnt_q >= DB_LAST) begin
          state_d = PRESSED;
          rcnt_d  = RD_LOAD;
        end else begin
          dcnt_d = dcnt_q + DB_ONE;
        end
      end
      PRESSED: begin
        if (!lvl) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DB_ONE;
        end else if (rcnt_q == '0) begin
          rcnt_d = RP_LOAD;
        end else begin
          rcnt_d = rcnt_q - R_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (lvl) begin
          state_d = PRESSED;
          rcnt_d  = RD_LOAD;
        end else if (dcnt_q >= DB_LAST) begin
          state_d = RELEASED;
        end else begin
          dcnt_d = dcnt_q + DB_ONE;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Pulse request: press acceptance or repeat expiry
  always_comb begin
    fire = 1'b0;
    unique case (state_q)
      RELEASED:
        fire = lvl && (DB_LAST == '0);
      PRESS_WAIT:
        fire = lvl && (dcnt_q >= DB_LAST);
      PRESSED:
        fire = lvl && (rcnt_q == '0);
      default:
        fire = 1'b0;
    endcase
  end

endmodule

// File: rtl/secmod.sv
// Seconds stage: 1 Hz prescaler, 0..59 counter with a
// one-cycle 60 carry, and minute-set button requests.
module secmod
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC  = 200_000,
  parameter int unsigned REPEAT_DELAY  = 5_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [31:0] seg,
  output logic        tick_1hz,
  output logic        up_min,
  output logic        down_min
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [31:0] SEG_ROLL = 32'(SEC_ROLL);
  localparam logic [31:0] SEG_LAST =
    32'(SEC_ROLL - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;
  logic [31:0]   seg_q, seg_d;
  logic          up_q, dn_q;
  logic          dfr_up, dfr_dn;
  logic          up_fire, dn_fire;
  logic          up_prs, dn_prs;
  logic          req_up, req_dn;
  logic          carry;

  assign seg      = seg_q;
  assign tick_1hz = tick_q;
  assign up_min   = up_q;
  assign down_min = dn_q;

  btn_cond #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_up),
    .pulse  (up_fire),
    .pressed(up_prs)
  );

  btn_cond #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_down),
    .pulse  (dn_fire),
    .pressed(dn_prs)
  );

  // Prescaler; an emitted tick always wraps and is honoured
  always_comb begin
    pcnt_d = pcnt_q;
    if (tick_q)
      pcnt_d = '0;
    else if (run && (pcnt_q != P_LAST))
      pcnt_d = pcnt_q + P_ONE;
    tick_d = run && (pcnt_d == P_LAST);
  end

  // Seconds: 60 lives one cycle, then back to 0
  always_comb begin
    seg_d = seg_q;
    if (seg_q == SEG_ROLL)
      seg_d = '0;
    else if (tick_q)
      seg_d = (seg_q >= SEG_LAST) ?
              SEG_ROLL : seg_q + 32'd1;
  end

  // Arbitration: conflicting presses cancel out
  always_comb begin
    req_up = up_fire;
    req_dn = dn_fire;
    if ((up_fire && dn_fire) || (up_prs && dn_prs)) begin
      req_up = 1'b0;
      req_dn = 1'b0;
    end
    carry = (seg_q == SEG_ROLL);
  end

  // Timekeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      seg_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      seg_q  <= seg_d;
    end
  end

  // Request outputs, held back one cycle off the carry slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      dfr_up <= 1'b0;
      dfr_dn <= 1'b0;
    end else if (carry) begin
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      dfr_up <= req_up | dfr_up;
      dfr_dn <= req_dn | dfr_dn;
    end else begin
      up_q   <= req_up | dfr_up;
      dn_q   <= req_dn | dfr_dn;
      dfr_up <= req_up & dfr_up;
      dfr_dn <= req_dn & dfr_dn;
    end
  end

endmodule

// File: tb/tb_secmod.sv
// Directed bench for secmod with small divider/debounce
// values; expected values are hand-derived per cycle.
module tb_secmod;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [31:0] seg;
  logic        tick_1hz;
  logic        up_min;
  logic        down_min;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  secmod #(
    .TICK_DIV     (4),
    .DEBOUNCE_CYC (3),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .seg     (seg),
    .tick_1hz(tick_1hz),
    .up_min  (up_min),
    .down_min(down_min)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d",
                  tag, got, exp);
  endtask

  // c = rising edges since reset release, run held 1
  function automatic int exp_seg(int c);
    int k;
    int r;
    k = c / 4;
    r = c % 4;
    if (k == 0) return 0;
    if ((k % 60 == 0) && (r == 0)) return 60;
    return k % 60;
  endfunction

  function automatic int exp_tick(int c);
    return (c % 4 == 3) ? 1 : 0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic quiet(input string tag, input int n);
    int cu;
    int cd;
    cu = 0;
    cd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (up_min) cu++;
      if (down_min) cd++;
    end
    chk({tag, "_up"}, cu, 0);
    chk({tag, "_dn"}, cd, 0);
  endtask

  initial begin
    int sixty2;
    logic [31:0] prev;
    int cnt;
    int pos [3];

    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_seg", seg, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_up", up_min, 0);
    chk("rst_dn", down_min, 0);

    // count up to 37, then reset mid-count
    reset = 1'b1;
    for (int c = 0; c <= 148; c++) begin
      if (c > 0) @(negedge clk);
      chk("pre_seg", seg, exp_seg(c));
    end
    chk("at37", seg, 37);
    reset = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 0);
    chk("mid_rst_tick", tick_1hz, 0);
    chk("mid_rst_up", up_min, 0);
    chk("mid_rst_dn", down_min, 0);
    @(negedge clk);
    reset = 1'b1;

    // rollover plus carry-slot deferral of up_min
    sixty2 = 0;
    prev = '0;
    for (int c = 0; c <= 252; c++) begin
      if (c > 0) @(negedge clk);
      chk("seg", seg, exp_seg(c));
      chk("tick", tick_1hz, exp_tick(c));
      if (seg == 60 && prev == 60) sixty2++;
      prev = seg;
      if (c == 3) chk("first_tick", tick_1hz, 1);
      if (c == 4) chk("first_sec", seg, 1);
      if (c == 238) chk("roll58", seg, 59);
      if (c == 239) chk("roll59", seg, 59);
      if (c == 240) chk("roll60", seg, 60);
      if (c == 241) chk("roll0", seg, 0);
      if (c == 241) chk("dfr_slot", up_min, 0);
      if (c == 242) chk("dfr_late", up_min, 1);
      if (c == 243) chk("dfr_width", up_min, 0);
      if (c == 249) chk("dfr_rep", up_min, 1);
      if (c == 235) btn_up = 1'b1;
    end
    chk("no_double_60", sixty2, 0);
    btn_up = 1'b0;
    do_reset();

    // freeze at 59 with button activity
    repeat (236) @(negedge clk);
    chk("pre_freeze", seg, 59);
    run = 1'b0;
    btn_up = 1'b1;
    cnt = 0;
    pos[0] = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("frz_seg", seg, 59);
      chk("frz_tick", tick_1hz, 0);
      if (up_min) begin
        if (cnt == 0) pos[0] = i;
        cnt++;
      end
      if (i == 18) btn_up = 1'b0;
    end
    chk("frz_pulses", cnt, 3);
    chk("frz_first", pos[0], 6);
    run = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("res_tick", tick_1hz, (j == 3) ? 1 : 0);
      chk("res_seg", seg,
          (j < 4) ? 59 : ((j == 4) ? 60 : 0));
    end
    do_reset();
    run = 1'b0;

    // short glitch is rejected
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    quiet("glitch", 15);

    // held press: entry, delay, period
    btn_up = 1'b1;
    cnt = 0;
    pos = '{-1, -1, -1};
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (up_min) begin
        if (cnt < 3) pos[cnt] = i;
        cnt++;
      end
      chk("hold_dn", down_min, 0);
    end
    btn_up = 1'b0;
    chk("hold_cnt", cnt, 3);
    chk("hold_p0", pos[0], 6);
    chk("hold_p1", pos[1], 14);
    chk("hold_p2", pos[2], 18);
    quiet("hold_rel", 15);

    // single down press
    btn_down = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("dn_pulse", down_min, (i == 6) ? 1 : 0);
      chk("dn_noup", up_min, 0);
    end
    btn_down = 1'b0;
    quiet("dn_rel", 15);

    // both pressed together cancels everything
    btn_up = 1'b1;
    btn_down = 1'b1;
    quiet("both", 30);
    btn_up = 1'b0;
    btn_down = 1'b0;
    quiet("both_rel", 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
